// File: rtl/axi_addr_beat_gen.sv
// axi_addr_beat_gen: expands an AXI burst command into per-beat addresses (FIXED/INCR/WRAP).
// Optional burst legality checking is enabled by defining AXI_BEAT_GEN_ERR_EN.
`default_nettype none

module axi_addr_beat_gen #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int ODW = 32,
   parameter int LEN = 8,
   parameter int IDW = 4
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic           i_cmd_valid,
   output logic           o_cmd_ready,
   input  logic [IDW-1:0] i_cmd_id,
   input  logic [AW-1:0]  i_cmd_addr,
   input  logic [LEN-1:0] i_cmd_len,
   input  logic [2:0]     i_cmd_size,
   input  logic [1:0]     i_cmd_burst,
   output logic           o_beat_valid,
   input  logic           i_beat_ready,
   output logic [AW-1:0]  o_beat_addr,
   output logic [IDW-1:0] o_beat_id,
   output logic [LEN-1:0] o_beat_idx,
   output logic           o_beat_last,
   output logic           o_beat_err
);

   localparam int       OLOG  = $clog2(ODW / 8);
   localparam int       DLOG  = $clog2(DW / 8);
   localparam logic [2:0] OLOG3 = 3'(OLOG);
   localparam logic [2:0] DLOG3 = 3'(DLOG);

   if (ODW > DW) begin : g_width_check
      $error("axi_addr_beat_gen: ODW must not exceed DW");
   end

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t         state;
   logic [LEN-1:0] len_q;
   logic [1:0]     burst_q;
   logic [AW-1:0]  inc_q;
   logic [AW-1:0]  mask_q;

   logic [2:0]     cmd_inc_log;
   logic [AW-1:0]  cmd_inc;
   logic [AW-1:0]  cmd_mask;
   logic [AW-1:0]  cmd_aligned;
   logic           cmd_accept;
   logic           beat_hs;
   logic [AW-1:0]  incr_addr;
   logic [AW-1:0]  next_addr;

   // Beat size is clamped to the output bus width; the wrap window is (len+1) beats.
   assign cmd_inc_log = (i_cmd_size > OLOG3) ? OLOG3 : i_cmd_size;
   assign cmd_inc     = AW'(1) << cmd_inc_log;
   assign cmd_mask    = ((AW'(i_cmd_len) + AW'(1)) << cmd_inc_log) - AW'(1);
   assign cmd_aligned = i_cmd_addr & ~(cmd_inc - AW'(1));

   assign o_cmd_ready = aresetn & ((state == IDLE) | (o_beat_valid & o_beat_last & i_beat_ready));
   assign cmd_accept  = i_cmd_valid & o_cmd_ready;
   assign beat_hs     = o_beat_valid & i_beat_ready;

   assign incr_addr = (o_beat_addr & ~(inc_q - AW'(1))) + inc_q;

   always_comb begin
      next_addr = incr_addr;
      case (burst_q)
         2'b00:   next_addr = o_beat_addr;
         2'b10:   next_addr = (o_beat_addr & ~mask_q) | (incr_addr & mask_q);
         default: next_addr = incr_addr;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state        <= IDLE;
         o_beat_valid <= 1'b0;
         o_beat_last  <= 1'b0;
         o_beat_idx   <= '0;
         o_beat_addr  <= '0;
         o_beat_id    <= '0;
         len_q        <= '0;
         burst_q      <= 2'b00;
         inc_q        <= '0;
         mask_q       <= '0;
      end else if (cmd_accept) begin
         state        <= BUSY;
         o_beat_valid <= 1'b1;
         o_beat_last  <= (i_cmd_len == '0);
         o_beat_idx   <= '0;
         o_beat_addr  <= i_cmd_addr;
         o_beat_id    <= i_cmd_id;
         len_q        <= i_cmd_len;
         burst_q      <= i_cmd_burst;
         inc_q        <= cmd_inc;
         mask_q       <= cmd_mask;
      end else if (beat_hs) begin
         if (o_beat_last) begin
            state        <= IDLE;
            o_beat_valid <= 1'b0;
            o_beat_last  <= 1'b0;
         end else begin
            o_beat_addr <= next_addr;
            o_beat_idx  <= o_beat_idx + LEN'(1);
            o_beat_last <= ((o_beat_idx + LEN'(1)) == len_q);
         end
      end
   end

`ifdef AXI_BEAT_GEN_ERR_EN
   logic [AW:0] last_byte;
   logic        wrap_bad;
   logic        size_bad;
   logic        cross_bad;
   logic        err_q;

   // Last byte touched by an INCR burst, one bit wider so a wrap past 2^AW is also caught.
   assign last_byte = {1'b0, cmd_aligned} + {1'b0, cmd_mask};
   assign wrap_bad  = (i_cmd_burst == 2'b10) &&
                      !((i_cmd_len == LEN'(1)) || (i_cmd_len == LEN'(3)) ||
                        (i_cmd_len == LEN'(7)) || (i_cmd_len == LEN'(15)));
   assign size_bad  = (i_cmd_size > DLOG3);
   assign cross_bad = i_cmd_burst[0] && (last_byte[AW:12] != {1'b0, i_cmd_addr[AW-1:12]});

   always_ff @(posedge aclk) begin
      if (!aresetn)
         err_q <= 1'b0;
      else if (cmd_accept)
         err_q <= wrap_bad | size_bad | cross_bad;
   end

   assign o_beat_err = err_q;
`else
   assign o_beat_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_addr_beat_gen.sv
// Directed self-checking bench for axi_addr_beat_gen (DW=64, ODW=32 so beat size clamping is exercised).
`default_nettype none

module tb_axi_addr_beat_gen;

   localparam int AW  = 32;
   localparam int LEN = 8;
   localparam int IDW = 4;
`ifdef AXI_BEAT_GEN_ERR_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           aresetn;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [IDW-1:0] cmd_id;
   logic [AW-1:0]  cmd_addr;
   logic [LEN-1:0] cmd_len;
   logic [2:0]     cmd_size;
   logic [1:0]     cmd_burst;
   logic           beat_valid;
   logic           beat_ready;
   logic [AW-1:0]  beat_addr;
   logic [IDW-1:0] beat_id;
   logic [LEN-1:0] beat_idx;
   logic           beat_last;
   logic           beat_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_addr_beat_gen #(.AW(AW), .DW(64), .ODW(32), .LEN(LEN), .IDW(IDW)) dut (
      .aclk(clk), .aresetn(aresetn),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_id(cmd_id),
      .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_size(cmd_size),
      .i_cmd_burst(cmd_burst), .o_beat_valid(beat_valid), .i_beat_ready(beat_ready),
      .o_beat_addr(beat_addr), .o_beat_id(beat_id), .o_beat_idx(beat_idx),
      .o_beat_last(beat_last), .o_beat_err(beat_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the presented beat at the current falling edge, then moves to the next one.
   task automatic expect_beat(input string tag, input logic [AW-1:0] a, input int idx,
                              input bit last, input int id, input bit err);
      chk({tag, ".valid"}, 64'(beat_valid), 64'(1));
      chk({tag, ".addr"},  64'(beat_addr),  64'(a));
      chk({tag, ".idx"},   64'(beat_idx),   64'(idx));
      chk({tag, ".last"},  64'(beat_last),  64'(last));
      chk({tag, ".id"},    64'(beat_id),    64'(id));
      chk({tag, ".err"},   64'(beat_err),   64'(err));
      @(negedge clk);
   endtask

   task automatic send(input int id, input logic [AW-1:0] a, input int len,
                       input int size, input logic [1:0] burst);
      cmd_id    = IDW'(id);
      cmd_addr  = a;
      cmd_len   = LEN'(len);
      cmd_size  = 3'(size);
      cmd_burst = burst;
      cmd_valid = 1'b1;
      chk("send.cmd_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      aresetn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_id     = '0;
      cmd_addr   = '0;
      cmd_len    = '0;
      cmd_size   = '0;
      cmd_burst  = '0;
      beat_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.valid", 64'(beat_valid), 64'(0));
      chk("rst.cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst.addr", 64'(beat_addr), 64'(0));
      chk("rst.idx", 64'(beat_idx), 64'(0));
      chk("rst.last", 64'(beat_last), 64'(0));
      chk("rst.err", 64'(beat_err), 64'(0));
      chk("rst.id", 64'(beat_id), 64'(0));
      aresetn = 1'b1;
      @(negedge clk);

      // INCR with unaligned start
      send(3, 32'h1002, 3, 2, 2'b01);
      chk("incr.busy_ready", 64'(cmd_ready), 64'(0));
      expect_beat("incr0", 32'h1002, 0, 0, 3, 0);
      expect_beat("incr1", 32'h1004, 1, 0, 3, 0);
      expect_beat("incr2", 32'h1008, 2, 0, 3, 0);
      expect_beat("incr3", 32'h100C, 3, 1, 3, 0);
      chk("incr.end_valid", 64'(beat_valid), 64'(0));

      // WRAP 16-byte window
      send(5, 32'h38, 3, 2, 2'b10);
      expect_beat("wrap0", 32'h38, 0, 0, 5, 0);
      expect_beat("wrap1", 32'h3C, 1, 0, 5, 0);
      expect_beat("wrap2", 32'h30, 2, 0, 5, 0);
      expect_beat("wrap3", 32'h34, 3, 1, 5, 0);
      chk("wrap.end_valid", 64'(beat_valid), 64'(0));

      // FIXED with a two-cycle stall on beat 1
      send(7, 32'h200, 2, 2, 2'b00);
      expect_beat("fix0", 32'h200, 0, 0, 7, 0);
      beat_ready = 1'b0;
      expect_beat("fix1s0", 32'h200, 1, 0, 7, 0);
      expect_beat("fix1s1", 32'h200, 1, 0, 7, 0);
      beat_ready = 1'b1;
      expect_beat("fix1", 32'h200, 1, 0, 7, 0);
      expect_beat("fix2", 32'h200, 2, 1, 7, 0);
      chk("fix.end_valid", 64'(beat_valid), 64'(0));

      // Back-to-back single-beat commands, no bubble
      send(1, 32'h100, 0, 2, 2'b01);
      cmd_id    = 4'd2;
      cmd_addr  = 32'h300;
      cmd_valid = 1'b1;
      chk("b2b.ready_on_last", 64'(cmd_ready), 64'(1));
      expect_beat("b2bA", 32'h100, 0, 1, 1, 0);
      cmd_valid = 1'b0;
      expect_beat("b2bB", 32'h300, 0, 1, 2, 0);
      chk("b2b.end_valid", 64'(beat_valid), 64'(0));

      // size 3 on a 32-bit output bus: step clamped to 4 bytes
      send(4, 32'h0, 1, 3, 2'b01);
      expect_beat("clamp0", 32'h0, 0, 0, 4, 0);
      expect_beat("clamp1", 32'h4, 1, 1, 4, 0);

      // WRAP with illegal length
      send(6, 32'h40, 2, 2, 2'b10);
      expect_beat("wrapbad0", 32'h40, 0, 0, 6, EN);
      expect_beat("wrapbad1", 32'h40, 1, 0, 6, EN);
      expect_beat("wrapbad2", 32'h40, 2, 1, 6, EN);

      // INCR crossing 4 KB
      send(8, 32'hFFC, 1, 2, 2'b01);
      expect_beat("cross0", 32'hFFC, 0, 0, 8, EN);
      expect_beat("cross1", 32'h1000, 1, 1, 8, EN);

      // size larger than the input bus
      send(9, 32'h20, 0, 4, 2'b01);
      expect_beat("bigsize", 32'h20, 0, 1, 9, EN);

      // reserved burst type acts as INCR
      send(10, 32'h11, 1, 1, 2'b11);
      expect_beat("rsv0", 32'h11, 0, 0, 10, 0);
      expect_beat("rsv1", 32'h12, 1, 1, 10, 0);

      // address wraps modulo 2^AW
      send(11, 32'hFFFF_FFFC, 1, 2, 2'b01);
      expect_beat("ovf0", 32'hFFFF_FFFC, 0, 0, 11, EN);
      expect_beat("ovf1", 32'h0, 1, 1, 11, EN);

      // reset in the middle of a burst drops remaining beats
      send(12, 32'h500, 3, 2, 2'b01);
      expect_beat("mid0", 32'h500, 0, 0, 12, 0);
      aresetn = 1'b0;
      @(negedge clk);
      chk("mid.rst_valid", 64'(beat_valid), 64'(0));
      chk("mid.rst_ready", 64'(cmd_ready), 64'(0));
      chk("mid.rst_addr", 64'(beat_addr), 64'(0));
      chk("mid.rst_idx", 64'(beat_idx), 64'(0));
      aresetn = 1'b1;
      @(negedge clk);
      chk("mid.post_valid0", 64'(beat_valid), 64'(0));
      @(negedge clk);
      chk("mid.post_valid1", 64'(beat_valid), 64'(0));
      chk("mid.post_ready", 64'(cmd_ready), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
